// File: rtl/calc_req_scheduler_if.sv
// Bundle between the requester ports, the shared ALU and the response bus.
// The slave modport is the scheduler's view; the master modport is the surrounding logic's view.
interface calc_req_scheduler_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 2
);
   localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   logic [NUM_PORTS-1:0]        req_valid;
   logic [NUM_PORTS-1:0]        req_ready;
   logic [NUM_PORTS*4-1:0]      req_cmd;
   logic [NUM_PORTS*DATA_W-1:0] req_data1;
   logic [NUM_PORTS*DATA_W-1:0] req_data2;
   logic [NUM_PORTS*TAG_W-1:0]  req_tag;

   logic                        alu_valid;
   logic [3:0]                  alu_cmd;
   logic [DATA_W-1:0]           alu_op1;
   logic [DATA_W-1:0]           alu_op2;
   logic [DATA_W-1:0]           alu_res_data;
   logic                        alu_res_ovf;

   logic                        out_valid;
   logic [PORT_W-1:0]           out_port;
   logic [1:0]                  out_resp;
   logic [TAG_W-1:0]            out_tag;
   logic [DATA_W-1:0]           out_data;

   // Request handshake: a transfer happens on a cycle where req_valid[p] and req_ready[p] are both high.
   modport slave (
      input  req_valid, req_cmd, req_data1, req_data2, req_tag,
      input  alu_res_data, alu_res_ovf,
      output req_ready,
      output alu_valid, alu_cmd, alu_op1, alu_op2,
      output out_valid, out_port, out_resp, out_tag, out_data
   );

   modport master (
      output req_valid, req_cmd, req_data1, req_data2, req_tag,
      output alu_res_data, alu_res_ovf,
      input  req_ready,
      input  alu_valid, alu_cmd, alu_op1, alu_op2,
      input  out_valid, out_port, out_resp, out_tag, out_data
   );
endinterface

// File: rtl/calc_req_scheduler.sv
// Round-robin scheduler sharing one fixed-latency ALU between several requester ports,
// with a tracking pipe that pairs each ALU result with its originating port and tag.
module calc_req_scheduler #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 32,
   parameter int TAG_W     = 2,
   parameter int ALU_LAT   = 2
) (
   input logic                 clk,
   input logic                 rst,
   calc_req_scheduler_if.slave bus
);
   localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int LAST = ALU_LAT - 1;

   localparam logic [3:0] CMD_NOP = 4'b0000;
   localparam logic [3:0] CMD_ADD = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_SHL = 4'b0101;
   localparam logic [3:0] CMD_SHR = 4'b0110;

   localparam logic [1:0] RESP_OK  = 2'b01;
   localparam logic [1:0] RESP_OVF = 2'b10;
   localparam logic [1:0] RESP_INV = 2'b11;

   function automatic logic cmd_is_valid(input logic [3:0] cmd);
      return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_SHL) || (cmd == CMD_SHR);
   endfunction

   logic [NUM_PORTS-1:0] hold_full_q, hold_full_d;
   logic [3:0]           hold_cmd_q [NUM_PORTS];
   logic [DATA_W-1:0]    hold_op1_q [NUM_PORTS];
   logic [DATA_W-1:0]    hold_op2_q [NUM_PORTS];
   logic [TAG_W-1:0]     hold_tag_q [NUM_PORTS];
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;

   logic [NUM_PORTS-1:0] grant;
   logic                 grant_valid;
   logic [PW-1:0]        grant_idx;
   logic                 gnt_cmd_ok;
   logic [NUM_PORTS-1:0] req_ready;
   logic [NUM_PORTS-1:0] capture;

   logic [ALU_LAT-1:0]   pipe_vld_q;
   logic [ALU_LAT-1:0]   pipe_inv_q;
   logic [PW-1:0]        pipe_port_q [ALU_LAT];
   logic [TAG_W-1:0]     pipe_tag_q  [ALU_LAT];

   logic                 out_valid_q;
   logic [PW-1:0]        out_port_q;
   logic [1:0]           out_resp_q, out_resp_d;
   logic [TAG_W-1:0]     out_tag_q;
   logic [DATA_W-1:0]    out_data_q, out_data_d;

   // First full hold reg at or after the pointer, wrapping around.
   always_comb begin
      logic [PW:0]   sum;
      logic [PW-1:0] cand;
      grant       = '0;
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      cand        = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         sum  = {1'b0, rr_ptr_q} + (PW+1)'(i);
         cand = (sum >= (PW+1)'(NUM_PORTS)) ? PW'(sum - (PW+1)'(NUM_PORTS)) : PW'(sum);
         if (!grant_valid && hold_full_q[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
      grant[grant_idx] = grant_valid;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (grant_valid) begin
         rr_ptr_d = (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + PW'(1);
      end
   end

   // A no-op is accepted but never occupies the hold reg.
   always_comb begin
      req_ready   = ~hold_full_q | grant;
      capture     = bus.req_valid & req_ready;
      hold_full_d = hold_full_q;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (capture[p]) begin
            hold_full_d[p] = (bus.req_cmd[4*p +: 4] != CMD_NOP);
         end else begin
            hold_full_d[p] = hold_full_q[p] & ~grant[p];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_full_q <= '0;
         rr_ptr_q    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            hold_cmd_q[p] <= '0;
            hold_op1_q[p] <= '0;
            hold_op2_q[p] <= '0;
            hold_tag_q[p] <= '0;
         end
      end else begin
         hold_full_q <= hold_full_d;
         rr_ptr_q    <= rr_ptr_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (capture[p]) begin
               hold_cmd_q[p] <= bus.req_cmd[4*p +: 4];
               hold_op1_q[p] <= bus.req_data1[DATA_W*p +: DATA_W];
               hold_op2_q[p] <= bus.req_data2[DATA_W*p +: DATA_W];
               hold_tag_q[p] <= bus.req_tag[TAG_W*p +: TAG_W];
            end
         end
      end
   end

   assign bus.req_ready = req_ready;
   assign gnt_cmd_ok    = cmd_is_valid(hold_cmd_q[grant_idx]);
   assign bus.alu_valid = grant_valid & gnt_cmd_ok;
   assign bus.alu_cmd   = hold_cmd_q[grant_idx];
   assign bus.alu_op1   = hold_op1_q[grant_idx];
   assign bus.alu_op2   = hold_op2_q[grant_idx];

   // Invalid commands still travel the pipe so their response keeps issue order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe_vld_q <= '0;
         pipe_inv_q <= '0;
         for (int i = 0; i < ALU_LAT; i++) begin
            pipe_port_q[i] <= '0;
            pipe_tag_q[i]  <= '0;
         end
      end else begin
         pipe_vld_q[0]  <= grant_valid;
         pipe_inv_q[0]  <= ~gnt_cmd_ok;
         pipe_port_q[0] <= grant_idx;
         pipe_tag_q[0]  <= hold_tag_q[grant_idx];
         for (int i = 1; i < ALU_LAT; i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_inv_q[i]  <= pipe_inv_q[i-1];
            pipe_port_q[i] <= pipe_port_q[i-1];
            pipe_tag_q[i]  <= pipe_tag_q[i-1];
         end
      end
   end

   always_comb begin
      out_resp_d = RESP_OK;
      out_data_d = bus.alu_res_data;
      if (pipe_inv_q[LAST]) begin
         out_resp_d = RESP_INV;
         out_data_d = '0;
      end else if (bus.alu_res_ovf) begin
         out_resp_d = RESP_OVF;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         out_port_q  <= '0;
         out_resp_q  <= '0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= pipe_vld_q[LAST];
         if (pipe_vld_q[LAST]) begin
            out_port_q <= pipe_port_q[LAST];
            out_resp_q <= out_resp_d;
            out_tag_q  <= pipe_tag_q[LAST];
            out_data_q <= out_data_d;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_port  = out_port_q;
   assign bus.out_resp  = out_resp_q;
   assign bus.out_tag   = out_tag_q;
   assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_calc_req_scheduler.sv
// Directed bench for calc_req_scheduler: per-port request queues feed a driver, a behavioural
// ALU answers issues, and a monitor checks issues and responses against expected queues.
module tb_calc_req_scheduler;
   localparam int NUM_PORTS = 4;
   localparam int DATA_W    = 32;
   localparam int TAG_W     = 2;
   localparam int ALU_LAT   = 2;
   localparam int PW        = 2;
   localparam int RSP_W     = PW + 2 + TAG_W + DATA_W;
   localparam int ISS_W     = 4 + 2*DATA_W;

   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SUB = 4'b0010;
   localparam logic [3:0] SHL = 4'b0101;
   localparam logic [3:0] SHR = 4'b0110;
   localparam logic [1:0] OK  = 2'b01;
   localparam logic [1:0] OVF = 2'b10;
   localparam logic [1:0] INV = 2'b11;

   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [TAG_W-1:0]  tag;
   } req_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   calc_req_scheduler_if #(.NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus_if ();

   calc_req_scheduler #(
      .NUM_PORTS(NUM_PORTS), .DATA_W(DATA_W), .TAG_W(TAG_W), .ALU_LAT(ALU_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   // ---------------- behavioural ALU ----------------
   logic [3:0]        m_cmd [ALU_LAT];
   logic [DATA_W-1:0] m_a   [ALU_LAT];
   logic [DATA_W-1:0] m_b   [ALU_LAT];
   logic [DATA_W:0]   alu_wide;

   always @(posedge clk) begin
      m_cmd[0] <= bus_if.alu_valid ? bus_if.alu_cmd : 4'b0000;
      m_a[0]   <= bus_if.alu_op1;
      m_b[0]   <= bus_if.alu_op2;
      for (int i = 1; i < ALU_LAT; i++) begin
         m_cmd[i] <= m_cmd[i-1];
         m_a[i]   <= m_a[i-1];
         m_b[i]   <= m_b[i-1];
      end
   end

   always_comb begin
      alu_wide = '0;
      case (m_cmd[ALU_LAT-1])
         ADD:     alu_wide = {1'b0, m_a[ALU_LAT-1]} + {1'b0, m_b[ALU_LAT-1]};
         SUB:     alu_wide = {1'b0, m_a[ALU_LAT-1]} - {1'b0, m_b[ALU_LAT-1]};
         SHL:     alu_wide = {1'b0, m_a[ALU_LAT-1] << m_b[ALU_LAT-1][4:0]};
         SHR:     alu_wide = {1'b0, m_a[ALU_LAT-1] >> m_b[ALU_LAT-1][4:0]};
         default: alu_wide = '0;
      endcase
      bus_if.alu_res_data = alu_wide[DATA_W-1:0];
      bus_if.alu_res_ovf  = alu_wide[DATA_W];
   end

   // ---------------- scoreboard state ----------------
   req_t             port_q [NUM_PORTS][$];
   logic [RSP_W-1:0] exp_q[$];
   logic [ISS_W-1:0] iss_q[$];
   int errors       = 0;
   int checks       = 0;
   int accept_cyc   = 0;
   int last_out_cyc = 0;

   task automatic chk(input string name, input logic [ISS_W-1:0] act, input logic [ISS_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pending();
      int n;
      n = exp_q.size() + iss_q.size();
      for (int p = 0; p < NUM_PORTS; p++) n += port_q[p].size();
      return n;
   endfunction

   task automatic send(input int p, input logic [3:0] cmd, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [1:0] resp, input logic [DATA_W-1:0] data);
      req_t r;
      r.cmd = cmd;
      r.a   = a;
      r.b   = b;
      r.tag = tag;
      port_q[p].push_back(r);
      if (cmd == ADD || cmd == SUB || cmd == SHL || cmd == SHR) iss_q.push_back({cmd, a, b});
      if (cmd != 4'b0000) exp_q.push_back({PW'(p), resp, tag, data});
   endtask

   // ---------------- driver ----------------
   task automatic driver();
      logic [NUM_PORTS-1:0]        v, fired;
      logic [NUM_PORTS*4-1:0]      c;
      logic [NUM_PORTS*DATA_W-1:0] d1, d2;
      logic [NUM_PORTS*TAG_W-1:0]  t;
      req_t                        r;
      forever begin
         @(negedge clk);
         v = '0; c = '0; d1 = '0; d2 = '0; t = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (rst && port_q[p].size() != 0) begin
               r = port_q[p][0];
               v[p]                  = 1'b1;
               c[4*p +: 4]           = r.cmd;
               d1[DATA_W*p +: DATA_W] = r.a;
               d2[DATA_W*p +: DATA_W] = r.b;
               t[TAG_W*p +: TAG_W]   = r.tag;
            end
         end
         bus_if.req_valid = v;
         bus_if.req_cmd   = c;
         bus_if.req_data1 = d1;
         bus_if.req_data2 = d2;
         bus_if.req_tag   = t;
         #1;
         fired = bus_if.req_valid & bus_if.req_ready;
         if (fired != '0) accept_cyc = cyc;
         @(posedge clk);
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (fired[p]) void'(port_q[p].pop_front());
         end
      end
   endtask

   // ---------------- monitor ----------------
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (bus_if.alu_valid) begin
            if (iss_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_issue: got cmd=%0b op1=0x%0h, required no issue",
                        bus_if.alu_cmd, bus_if.alu_op1);
            end else begin
               chk("issue", {bus_if.alu_cmd, bus_if.alu_op1, bus_if.alu_op2}, iss_q.pop_front());
            end
         end
         if (bus_if.out_valid) begin
            last_out_cyc = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out: got port=%0d resp=%0b tag=%0d data=0x%0h, required no response",
                        bus_if.out_port, bus_if.out_resp, bus_if.out_tag, bus_if.out_data);
            end else begin
               chk("response",
                   ISS_W'({bus_if.out_port, bus_if.out_resp, bus_if.out_tag, bus_if.out_data}),
                   ISS_W'(exp_q.pop_front()));
            end
         end
      end
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pending() == 0) break;
         @(negedge clk);
         #1;
      end
      chk(name, ISS_W'(pending()), '0);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag_s);
      chk({tag_s, "_out_valid"}, ISS_W'(bus_if.out_valid), '0);
      chk({tag_s, "_out_port"},  ISS_W'(bus_if.out_port),  '0);
      chk({tag_s, "_out_resp"},  ISS_W'(bus_if.out_resp),  '0);
      chk({tag_s, "_out_tag"},   ISS_W'(bus_if.out_tag),   '0);
      chk({tag_s, "_out_data"},  ISS_W'(bus_if.out_data),  '0);
      chk({tag_s, "_alu_valid"}, ISS_W'(bus_if.alu_valid), '0);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_outputs_zero("rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_req_ready", ISS_W'(bus_if.req_ready), ISS_W'({NUM_PORTS{1'b1}}));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus_if.req_valid = '0;
      bus_if.req_cmd   = '0;
      bus_if.req_data1 = '0;
      bus_if.req_data2 = '0;
      bus_if.req_tag   = '0;
      fork
         monitor();
         driver();
         begin
            #500000;
            $display("FAIL watchdog: got no completion, required completion within time limit");
            $fatal(1, "watchdog expired");
         end
      join_none

      reset_dut();

      // Lone add, checks end-to-end latency.
      send(0, ADD, 32'd5, 32'd7, 2'd2, OK, 32'd12);
      wait_drain("t1_drain", 40);
      chk("t1_latency", ISS_W'(last_out_cyc - accept_cyc), ISS_W'(4));

      // All ports at once from pointer 0.
      reset_dut();
      send(0, ADD, 32'd1,   32'd2, 2'd0, OK, 32'd3);
      send(1, SUB, 32'd10,  32'd3, 2'd1, OK, 32'd7);
      send(2, SHL, 32'd1,   32'd4, 2'd2, OK, 32'd16);
      send(3, SHR, 32'd256, 32'd2, 2'd3, OK, 32'd64);
      wait_drain("t2_drain", 60);

      // Unsupported command: no issue, invalid response.
      send(2, 4'b0011, 32'd9, 32'd9, 2'd1, INV, 32'd0);
      wait_drain("t3_drain", 40);
      chk("t3_latency", ISS_W'(last_out_cyc - accept_cyc), ISS_W'(4));

      // Underflow, then a no-op that must vanish.
      send(1, SUB, 32'd0, 32'd1, 2'd0, OVF, 32'hFFFF_FFFF);
      send(1, 4'b0000, 32'd3, 32'd4, 2'd3, 2'b00, 32'd0);
      wait_drain("t4_drain", 40);

      // Two ports kept busy alternate grants.
      reset_dut();
      send(0, ADD, 32'd100, 32'd1, 2'd0, OK, 32'd101);
      send(3, SUB, 32'd50,  32'd1, 2'd3, OK, 32'd49);
      send(0, ADD, 32'd100, 32'd2, 2'd1, OK, 32'd102);
      send(3, SUB, 32'd50,  32'd2, 2'd0, OK, 32'd48);
      send(0, ADD, 32'd100, 32'd3, 2'd2, OK, 32'd103);
      send(3, SUB, 32'd50,  32'd3, 2'd1, OK, 32'd47);
      wait_drain("t5_drain", 60);

      // Reset with two requests in flight.
      send(2, ADD, 32'd1, 32'd1, 2'd1, OK, 32'd2);
      send(3, ADD, 32'd2, 32'd2, 2'd2, OK, 32'd4);
      for (int i = 0; i < 20; i++) begin
         if (iss_q.size() == 0) break;
         @(negedge clk);
         #1;
      end
      chk("t6_issued", ISS_W'(iss_q.size()), '0);
      #2;
      rst = 1'b0;
      #1;
      check_outputs_zero("t6_midrst");
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (8) @(negedge clk);
      #1;
      chk("t6_req_ready", ISS_W'(bus_if.req_ready), ISS_W'({NUM_PORTS{1'b1}}));
      chk("t6_leftover", ISS_W'(pending()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
